// File: rtl/apb_arbiter_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    localparam int REQ_I2C  = 0;
    localparam int REQ_HOST = 1;

endpackage

// File: rtl/apb_arbiter_if.sv
// APB bus between the arbiter (master modport) and the single-port memory (slave modport).
interface apb_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pwrite;
    logic              pread;
    logic              penable;
    logic              pslverr;
    logic              pready;
    logic              pslverr_out;

    modport master (
        output paddr, pwdata, pwrite, pread, penable, pslverr,
        input  prdata, pready, pslverr_out
    );

    modport slave (
        input  paddr, pwdata, pwrite, pread, penable, pslverr,
        output prdata, pready, pslverr_out
    );

endinterface

// File: rtl/apb_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant; the last-grant pointer is held by the parent.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_req
);

    // On contention the requester that was not served last wins.
    always_comb begin
        any_req = |req_valid;
        grant   = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master with round-robin arbitration and local address range check.
// Optional ACCESS-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_SIZE = 128,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    apb_arbiter_if.master       apb
);

    state_t            state, state_next;
    logic              grant, any_req, accept, range_err, timed_out;
    logic              last_grant, cur, wr_q, err_q;
    logic [ADDR_W-1:0] sel_addr, paddr_q;
    logic [DATA_W-1:0] sel_wdata, pwdata_q, rdata_q;
    logic              sel_write;

    rr_arbiter2 u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_req    (any_req)
    );

    assign sel_addr  = req_addr[grant*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[grant*DATA_W +: DATA_W];
    assign sel_write = req_write[grant];
    assign range_err = (32'(sel_addr) >= MEM_SIZE);
    // Gated by rst_n so the combinational accept stays low while reset is held.
    assign accept    = rst_n && (state == IDLE) && any_req;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] acc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_cnt <= '0;
        else if (state == ACCESS && !apb.pready)
            acc_cnt <= acc_cnt + 1'b1;
        else
            acc_cnt <= '0;
    end

    assign timed_out = (state == ACCESS) && !apb.pready && (acc_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = range_err ? RESP : SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (apb.pready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction context: captured on accept, response fields updated when ACCESS ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cur        <= 1'b0;
            wr_q       <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                cur        <= grant;
                wr_q       <= sel_write;
                paddr_q    <= sel_addr;
                pwdata_q   <= sel_wdata;
                rdata_q    <= '0;
                err_q      <= range_err;
            end
            if (state == ACCESS && apb.pready) begin
                rdata_q <= wr_q ? '0 : apb.prdata;
                err_q   <= apb.pslverr_out;
            end else if (timed_out) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign req_ready[REQ_I2C]  = accept && (grant == 1'(REQ_I2C));
    assign req_ready[REQ_HOST] = accept && (grant == 1'(REQ_HOST));
    assign rsp_valid[REQ_I2C]  = (state == RESP) && (cur == 1'(REQ_I2C));
    assign rsp_valid[REQ_HOST] = (state == RESP) && (cur == 1'(REQ_HOST));
    assign rsp_rdata           = (state == RESP) ? rdata_q : '0;
    assign rsp_err             = (state == RESP) && err_q;

    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pwrite  = ((state == SETUP) || (state == ACCESS)) && wr_q;
    assign apb.pread   = ((state == SETUP) || (state == ACCESS)) && !wr_q;
    assign apb.penable = (state == ACCESS);
    assign apb.pslverr = 1'b0;

endmodule

// File: tb/tb_apb_arbiter.sv
// Randomized self-checking bench for apb_arbiter against a transaction-level reference model.
module tb_apb_arbiter;

    localparam int MEM_SIZE = 100;
    localparam int TIMEOUT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [13:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    int          total = 0;
    int          bad = 0;
    int          model_last = 1;
    int          wait_cycles = 0;
    logic        slv_err = 1'b0;
    int          apb_act = 0;
    int          acc_cnt = 0;
    logic        init_done = 1'b0;
    logic [7:0]  mem [128];
    logic [7:0]  ref_mem [128];

    apb_arbiter_if #(.ADDR_W(7), .DATA_W(8)) apb ();

    apb_arbiter #(.ADDR_W(7), .DATA_W(8), .MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    always #5 clk = ~clk;

    // Behavioural slave: programmable wait states, optional write error, counts APB cycles.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'((i * 37 + 11) & 255);
            init_done <= 1'b1;
        end else if (apb.penable && apb.pready) begin
            if (apb.pwrite && !slv_err) mem[apb.paddr] <= apb.pwdata;
        end
        if (apb.pread || apb.pwrite) apb_act <= apb_act + 1;
        if (apb.penable && !apb.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign apb.pready      = apb.penable && (acc_cnt >= wait_cycles);
    assign apb.prdata      = mem[apb.paddr];
    assign apb.pslverr_out = slv_err;

    function automatic void model_txn(input logic wr, input logic [6:0] addr, input logic [7:0] wd,
                                      output int lat, output logic [7:0] rd, output logic er, output int cyc);
        if (int'(addr) >= MEM_SIZE) begin
            lat = 1; rd = '0; er = 1'b1; cyc = 0;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (wait_cycles >= TIMEOUT) begin
            lat = 2 + TIMEOUT; rd = '0; er = 1'b1; cyc = 1 + TIMEOUT;
        end
`endif
        else begin
            lat = 3 + wait_cycles;
            cyc = 2 + wait_cycles;
            er  = slv_err;
            rd  = wr ? 8'h00 : ref_mem[addr];
            if (wr && !slv_err) ref_mem[addr] = wd;
        end
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    task automatic single_txn(input int r, input logic wr, input logic [6:0] addr, input logic [7:0] wd,
                              output int lat, output logic [7:0] rd, output logic er, output logic [1:0] rv);
        bit acc;
        acc = 1'b0;
        lat = -1; rd = '0; er = 1'b0; rv = '0;
        @(negedge clk);
        req_valid = '0;
        req_write[r] = wr;
        req_addr[r*7 +: 7] = addr;
        req_wdata[r*8 +: 8] = wd;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (req_ready[r]) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) begin
            req_valid = '0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                lat = k + 1; rd = rsp_rdata; er = rsp_err; rv = rsp_valid;
                break;
            end
        end
    endtask

    // Runs one isolated transaction and checks latency, response and APB activity.
    task automatic run_checked(input string tag, input int r, input logic wr, input logic [6:0] addr,
                               input logic [7:0] wd);
        int lat, elat, ecyc, act0;
        logic [7:0] rd, erd;
        logic er, eer;
        logic [1:0] rv;
        act0 = apb_act;
        model_txn(wr, addr, wd, elat, erd, eer, ecyc);
        model_last = r;
        single_txn(r, wr, addr, wd, lat, rd, er, rv);
        total++;
        if (lat !== elat) begin
            bad++; $display("FAIL %s_latency got=%0d want=%0d", tag, lat, elat);
        end
        total++;
        if ({rv, er, rd} !== {2'(1 << r), eer, erd}) begin
            bad++; $display("FAIL %s_response got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
                            tag, rv, er, rd, 2'(1 << r), eer, erd);
        end
        total++;
        if (apb_act - act0 !== ecyc) begin
            bad++; $display("FAIL %s_apb_cycles got=%0d want=%0d", tag, apb_act - act0, ecyc);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 2'b11; req_write = 2'b11; req_addr = {7'd5, 7'd6}; req_wdata = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 11'b0) begin
            bad++; $display("FAIL reset_rsp got=%b want=0", {rsp_valid, rsp_err, rsp_rdata});
        end
        total++;
        if ({apb.paddr, apb.pwdata, apb.pwrite, apb.pread, apb.penable, apb.pslverr} !== 19'b0) begin
            bad++; $display("FAIL reset_apb got=%b want=0",
                            {apb.paddr, apb.pwdata, apb.pwrite, apb.pread, apb.penable, apb.pslverr});
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    task automatic test_write_read;
        int lat;
        logic [7:0] rd;
        logic er;
        logic [1:0] rv;
        wait_cycles = 0;
        run_checked("wr50", 0, 1'b1, 7'd50, 8'hAA);
        single_txn(0, 1'b0, 7'd50, 8'h00, lat, rd, er, rv);
        model_last = 0;
        total++;
        if ({lat, rd, er} !== {32'd3, 8'hAA, 1'b0}) begin
            bad++; $display("FAIL rd50 got lat=%0d rd=%h err=%b want lat=3 rd=aa err=0", lat, rd, er);
        end
        slv_err = 1'b1;
        run_checked("slverr_wr", 1, 1'b1, 7'd60, 8'h77);
        slv_err = 1'b0;
    endtask

    task automatic test_contention;
        int r0k, r1k, a1k, exp_first, elat, ecyc;
        logic [7:0] rd1, erd;
        logic er1, eer;
        r0k = -1; r1k = -1; a1k = -1; rd1 = '0; er1 = 1'b0;
        wait_cycles = 0;
        do_reset();
        @(negedge clk);
        req_write = 2'b01; req_addr = {7'd51, 7'd51}; req_wdata = {8'h00, 8'hAB};
        req_valid = 2'b11;
        #1;
        exp_first = 1 - model_last;
        total++;
        if (req_ready !== 2'(1 << exp_first)) begin
            bad++; $display("FAIL contention_first_grant got=%b want=%b", req_ready, 2'(1 << exp_first));
        end
        model_txn(1'b1, 7'd51, 8'hAB, elat, erd, eer, ecyc);
        model_last = 0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid[0] && r0k < 0) r0k = k;
            if (rsp_valid[1] && r1k < 0) begin
                r1k = k; rd1 = rsp_rdata; er1 = rsp_err;
            end
            if (req_ready[1] && a1k < 0) begin
                a1k = k;
                @(posedge clk);
                #1;
                req_valid[1] = 1'b0;
            end
        end
        req_valid = '0;
        total++;
        if (r0k !== elat - 1) begin
            bad++; $display("FAIL contention_req0_rsp got=%0d want=%0d", r0k, elat - 1);
        end
        total++;
        if (a1k !== 3) begin
            bad++; $display("FAIL contention_req1_wait got=%0d want=3", a1k);
        end
        model_txn(1'b0, 7'd51, 8'h00, elat, erd, eer, ecyc);
        model_last = 1;
        total++;
        if ({r1k, rd1, er1} !== {a1k + elat, erd, eer}) begin
            bad++; $display("FAIL contention_req1_rsp got k=%0d rd=%h err=%b want k=%0d rd=%h err=%b",
                            r1k, rd1, er1, a1k + elat, erd, eer);
        end
    endtask

    task automatic test_alternate;
        int n, expg, cycles;
        n = 0; cycles = 0;
        wait_cycles = 0;
        @(negedge clk);
        req_write = 2'b00; req_addr = {7'd21, 7'd20};
        req_valid = 2'b11;
        while (n < 6 && cycles < 80) begin
            #1;
            if (req_ready != 2'b00) begin
                expg = 1 - model_last;
                total++;
                if (req_ready !== 2'(1 << expg)) begin
                    bad++; $display("FAIL alternate_grant%0d got=%b want=%b", n, req_ready, 2'(1 << expg));
                end
                model_last = expg;
                n++;
            end
            @(negedge clk);
            cycles++;
        end
        req_valid = '0;
        total++;
        if (n !== 6) begin
            bad++; $display("FAIL alternate_count got=%0d want=6", n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_range_error;
        wait_cycles = 0;
        run_checked("range110", 1, 1'b0, 7'd110, 8'h00);
        run_checked("range99", 0, 1'b0, 7'd99, 8'h00);
        run_checked("range100", 0, 1'b1, 7'd100, 8'h55);
    endtask

    task automatic test_wait_states;
        wait_cycles = 1;
        run_checked("wait1", 0, 1'b0, 7'd50, 8'h00);
        wait_cycles = 3;
        run_checked("wait3", 1, 1'b0, 7'd51, 8'h00);
        wait_cycles = 3;
        run_checked("wait3_wr", 0, 1'b1, 7'd52, 8'h19);
        wait_cycles = 0;
    endtask

    task automatic test_random;
        int r;
        logic wr;
        logic [6:0] addr;
        logic [7:0] wd;
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            addr = 7'($urandom_range(0, 127));
            wd = 8'($urandom);
            wait_cycles = int'($urandom_range(0, 3));
            run_checked($sformatf("rand%0d", i), r, wr, addr, wd);
        end
        wait_cycles = 0;
    endtask

    task automatic test_reset_mid;
        logic hit;
        hit = 1'b0;
        wait_cycles = 5;
        @(negedge clk);
        req_write[0] = 1'b0; req_addr[6:0] = 7'd10; req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL reset_mid_accept got=%b want=01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        total++;
        if (apb.penable !== 1'b1) begin
            bad++; $display("FAIL reset_mid_in_access got=%b want=1", apb.penable);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, apb.paddr, apb.pwdata, apb.pwrite, apb.pread,
             apb.penable, apb.pslverr} !== 32'b0) begin
            bad++; $display("FAIL reset_mid_outputs got=%b want=0",
                            {req_ready, rsp_valid, rsp_err, rsp_rdata, apb.paddr, apb.pwdata,
                             apb.pwrite, apb.pread, apb.penable, apb.pslverr});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (rsp_valid !== 2'b00) hit = 1'b1;
        end
        total++;
        if (hit !== 1'b0) begin
            bad++; $display("FAIL reset_mid_no_rsp got=%b want=0", hit);
        end
        model_last = 1;
        wait_cycles = 0;
        run_checked("post_reset_wr", 1, 1'b1, 7'd30, 8'h3C);
        run_checked("post_reset_rd", 0, 1'b0, 7'd30, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
        test_reset();
        test_write_read();
        test_contention();
        test_alternate();
        test_range_error();
        test_wait_states();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-requester APB master that shares the single-port `apb_slave` memory (7-bit address, 8-bit data) between the I2C bridge front end (requester 0) and the host/debug port (requester 1). Accepts one request at a time with round-robin fairness and sequences the APB setup and access phases. Waits on `apb_pready`, returns read data and slave error to the granted requester, and range-checks addresses before issuing any bus cycle.

## Interface
- `ADDR_W`, 7, APB address width
- `DATA_W`, 8, APB data width
- `MEM_SIZE`, 128, number of valid slave locations; addresses >= MEM_SIZE are rejected locally
- `TIMEOUT`, 16, maximum ACCESS cycles before abort (only with `APB_ARB_TIMEOUT_EN`)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  2  per-requester request strobe, held until accepted
- `req_write`  in  2  per-requester 1=write, 0=read
- `req_addr`  in  2*ADDR_W  per-requester address, [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  2*DATA_W  per-requester write data
- `req_ready`  out  2  accept pulse, at most one bit set
- `rsp_valid`  out  2  one-cycle completion pulse to the accepted requester
- `rsp_rdata`  out  DATA_W  read data, valid with rsp_valid (0 for writes and errors)
- `rsp_err`  out  1  error flag, valid with rsp_valid
- `apb_paddr`, `apb_pwdata`  out  ADDR_W / DATA_W  registered address/data to slave
- `apb_pwrite`, `apb_pread`, `apb_penable`  out  1  APB phase controls
- `apb_pslverr`  out  1  driven constant 0
- `apb_prdata`  in  DATA_W; `apb_pready`, `apb_pslverr_out`  in  1  slave responses

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any `req_valid`, grant one requester. `req_ready[g]` is combinational, high in IDLE only. Capture write, addr and wdata, then go to SETUP. If addr >= MEM_SIZE, go directly to RESP with err=1 and issue no APB cycle.
- SETUP (1 cycle): paddr/pwdata valid, pwrite or pread asserted, penable=0.
- ACCESS: penable=1, controls held. Stay until `apb_pready`=1 is sampled, then capture `apb_prdata` (reads only) and `apb_pslverr_out`, and go to RESP.
- RESP (1 cycle): `rsp_valid[g]`=1 with rdata/err. All APB controls are 0. Return to IDLE.
- Arbitration: round-robin on a 1-bit last-grant pointer. On contention, the requester not served last wins. A lone requester always wins. After reset, the pointer favours requester 0.
- Reset (asynchronous, any state): FSM to IDLE, pointer reset, and all outputs to 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, all apb_*). An in-flight transaction is dropped with no response.
- A requester must not deassert `req_valid` before `req_ready`; behaviour is undefined otherwise.

## Timing
- Accept at edge N. SETUP in cycle N+1. ACCESS from N+2. RESP in the cycle after pready is sampled.
- Zero-wait slave: `rsp_valid` at cycle N+3. Each extra pready wait cycle adds 1.
- Range error: `rsp_valid` at N+1.
- Throughput: one transaction per 4 cycles at best. The next `req_ready` is possible in the cycle after RESP.
- Same-cycle requests from both requesters: one is accepted; the other waits at least 4 cycles.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined: an ACCESS-cycle counter (width clog2(TIMEOUT+1)) runs. If pready is still low after TIMEOUT ACCESS cycles, the FSM drops penable/pwrite/pread and goes to RESP with err=1, rdata=0.
- Undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package `apb_arb_pkg`:
  - FSM state enum
  - default ADDR_W/DATA_W constants
  - requester index constants (REQ_I2C=0, REQ_HOST=1)
- Sub-module `rr_arbiter2`: combinational grant from `req_valid` plus the last-grant pointer. The pointer register lives in the parent and updates on accept.

## Test plan
- Req0 writes 0xAA to 50, then reads 50 -> APB write then read; rsp_rdata=0xAA, err=0; rsp_valid 3 cycles after accept (zero-wait).
- Both requesters valid in the same cycle after reset (req0 write 51/0xAB, req1 read 51) -> req0 served first; req1 then reads 0xAB.
- Both held valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- MEM_SIZE=100, read addr 110 -> rsp_valid next cycle, err=1, rdata=0, apb_pread/penable never asserted.
- Slave holds pready low 3 cycles; with `APB_ARB_TIMEOUT_EN` and TIMEOUT=2 -> abort, err=1. Without the macro -> completes with 3 extra cycles of latency.
- rst_n asserted during ACCESS -> all outputs 0 immediately, no rsp_valid; the next request after release is served normally.
